// File: rtl/fpadd_pkg.sv
// Shared widths, flag bit positions and the result payload carried from fpadd to writeback.
package fpadd_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned TAG_W  = 5;

    localparam int unsigned NV = 4;
    localparam int unsigned DZ = 3;
    localparam int unsigned OF = 2;
    localparam int unsigned UF = 1;
    localparam int unsigned NX = 0;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [FLAG_W-1:0] flags;
        logic              denorm;
        logic [TAG_W-1:0]  tag;
    } fpres_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/fpres_skid_buf.sv
// Two-entry valid/ready skid buffer on fpres_t; main reg M drives the output, skid reg S
// absorbs the one op that arrives while the consumer stalls.
module fpres_skid_buf
    import fpadd_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  fpres_t in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output fpres_t out_data
);

    skid_state_e state_q, state_d;
    logic        in_ready_q, out_valid_q;
    fpres_t      m_q, s_q;
    logic        in_xfer, out_xfer;
    logic        load_m, load_s, m_from_s;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // State register; handshake outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_xfer) state_d = ST_ONE;
            ST_ONE: begin
                if (in_xfer && !out_xfer)      state_d = ST_TWO;
                else if (!in_xfer && out_xfer) state_d = ST_EMPTY;
            end
            ST_TWO:   if (out_xfer) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        load_m   = 1'b0;
        load_s   = 1'b0;
        m_from_s = 1'b0;
        case (state_q)
            ST_EMPTY: load_m = in_xfer;
            ST_ONE: begin
                load_m = in_xfer & out_xfer;
                load_s = in_xfer & ~out_xfer;
            end
            ST_TWO: begin
                load_m   = out_xfer;
                m_from_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Payload registers; reset clears them so the output bus reads zero after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            if (load_m) m_q <= m_from_s ? s_q : in_data;
            if (load_s) s_q <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = m_q;

endmodule

// File: rtl/fpadd_result_stage.sv
// Registered fpadd output stage with skid buffering and sticky fflags accumulation.
// Define FPADD_RESULT_PERFCNT_EN to add commit / denorm-commit performance counters.
module fpadd_result_stage
    import fpadd_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [FLAG_W-1:0] in_flags,
    input  logic              in_denorm,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [FLAG_W-1:0] out_flags,
    output logic              out_denorm,
    output logic [TAG_W-1:0]  out_tag,
    input  logic              flags_clr,
`ifdef FPADD_RESULT_PERFCNT_EN
    output logic [31:0]       perf_commits,
    output logic [31:0]       perf_denorms,
`endif
    output logic [FLAG_W-1:0] sticky_flags
);

    fpres_t            in_data, out_data;
    logic              commit;
    logic [FLAG_W-1:0] sticky_q, sticky_d;

    assign in_data = '{result: in_result, flags: in_flags, denorm: in_denorm, tag: in_tag};

    fpres_skid_buf u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign out_result = out_data.result;
    assign out_flags  = out_data.flags;
    assign out_denorm = out_data.denorm;
    assign out_tag    = out_data.tag;
    assign commit     = out_valid & out_ready;

    // A clear colliding with a commit keeps the committing op's flags.
    always_comb begin
        sticky_d = sticky_q;
        if (commit)         sticky_d = flags_clr ? out_flags : (sticky_q | out_flags);
        else if (flags_clr) sticky_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) sticky_q <= '0;
        else          sticky_q <= sticky_d;
    end

    assign sticky_flags = sticky_q;

`ifdef FPADD_RESULT_PERFCNT_EN
    logic [31:0] perf_commits_q, perf_denorms_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_commits_q <= '0;
            perf_denorms_q <= '0;
        end else if (commit) begin
            perf_commits_q <= perf_commits_q + 32'(1);
            if (out_denorm) perf_denorms_q <= perf_denorms_q + 32'(1);
        end
    end

    assign perf_commits = perf_commits_q;
    assign perf_denorms = perf_denorms_q;
`endif

endmodule
